// File: rtl/adc_integ_pkg.sv
// Shared constants and FSM state encoding for the ADC pulse integrator.
package adc_integ_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SAMPLES    = 8;
  localparam int BEAT_SUM_W = SAMPLE_W + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    INTEG = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/adc_beat_adder.sv
// Sums the eight signed samples of one ADC beat into a registered 19-bit result,
// with a valid bit travelling alongside so the accumulator knows what to add.
module adc_beat_adder
  import adc_integ_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SAMPLES*SAMPLE_W-1:0]  data,
  input  logic                         in_valid,
  output logic signed [BEAT_SUM_W-1:0] sum,
  output logic                         out_valid
);

  logic signed [BEAT_SUM_W-1:0] sum_s;
  logic signed [BEAT_SUM_W-1:0] sum_r;
  logic                         valid_r;

  // Sign-extend every sample to the beat-sum width and add them up.
  always_comb begin
    sum_s = {BEAT_SUM_W{1'b0}};
    for (int i = 0; i < SAMPLES; i++) begin
      sum_s = sum_s + {{(BEAT_SUM_W-SAMPLE_W){data[i*SAMPLE_W+SAMPLE_W-1]}},
                       data[i*SAMPLE_W +: SAMPLE_W]};
    end
  end

  // Single pipeline stage: capture the sum only for beats that are integrated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_r   <= {BEAT_SUM_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        sum_r <= sum_s;
      end else begin
        sum_r <= sum_r;
      end
    end
  end

  assign sum       = sum_r;
  assign out_valid = valid_r;

endmodule

// File: rtl/adc_pulse_integrator.sv
// Integrates a triggered window of ADC beats into one signed result per pulse,
// delivered on an AXI-Stream that holds the result until it is accepted.
module adc_pulse_integrator #(
  parameter int SAMPLES  = adc_integ_pkg::SAMPLES,
  parameter int SAMPLE_W = adc_integ_pkg::SAMPLE_W,
  parameter int CNT_W    = 8,
  parameter int ACC_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trig,
  input  logic [CNT_W-1:0]            delay_beats,
  input  logic [CNT_W-1:0]            win_len,
  input  logic [SAMPLES*SAMPLE_W-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [ACC_W-1:0]            m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic                        overrun
);

  import adc_integ_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                        state_r;
  state_t                        next_state_s;
  logic [CNT_W-1:0]              cnt_r;
  logic [CNT_W-1:0]              delay_r;
  logic [CNT_W-1:0]              win_r;
  logic signed [ACC_W-1:0]       acc_r;
  logic [ACC_W-1:0]              tdata_r;
  logic                          tvalid_r;
  logic                          busy_r;
  logic                          overrun_r;
  logic                          tready_r;
  logic                          adder_in_valid_s;
  logic                          integ_entry_s;
  logic                          load_result_s;
  logic signed [BEAT_SUM_W-1:0]  beat_sum_s;
  logic                          beat_valid_s;

  adc_beat_adder u_beat_adder (
    .clk       (clk),
    .rst       (rst),
    .data      (s_axis_tdata),
    .in_valid  (adder_in_valid_s),
    .sum       (beat_sum_s),
    .out_valid (beat_valid_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; only valid beats advance DELAY and INTEG.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (trig) begin
          next_state_s = (delay_beats == CNT_ZERO) ? INTEG : DELAY;
        end else begin
          next_state_s = IDLE;
        end
      end
      DELAY: begin
        if (s_axis_tvalid && (cnt_r == delay_r - CNT_ONE)) begin
          next_state_s = INTEG;
        end else begin
          next_state_s = DELAY;
        end
      end
      INTEG: begin
        if (s_axis_tvalid && (cnt_r == win_r - CNT_ONE)) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = INTEG;
        end
      end
      DRAIN: begin
        if (!beat_valid_s) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = DRAIN;
        end
      end
      HOLD: begin
        if (m_axis_tready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: datapath strobes derived from the current and next state.
  always_comb begin
    adder_in_valid_s = 1'b0;
    integ_entry_s    = 1'b0;
    load_result_s    = 1'b0;
    case (state_r)
      INTEG:   adder_in_valid_s = s_axis_tvalid;
      DRAIN:   load_result_s    = (next_state_s == HOLD);
      default: adder_in_valid_s = 1'b0;
    endcase
    if ((state_r != INTEG) && (next_state_s == INTEG)) begin
      integ_entry_s = 1'b1;
    end else begin
      integ_entry_s = 1'b0;
    end
  end

  // Window parameters are latched on an accepted trigger; the counter restarts per phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r   <= CNT_ZERO;
      delay_r <= CNT_ZERO;
      win_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig) begin
            delay_r <= delay_beats;
            win_r   <= (win_len == CNT_ZERO) ? CNT_ONE : win_len;
            cnt_r   <= CNT_ZERO;
          end
        end
        DELAY, INTEG: begin
          if (s_axis_tvalid) begin
            cnt_r <= (next_state_s != state_r) ? CNT_ZERO : cnt_r + CNT_ONE;
          end
        end
        default: cnt_r <= CNT_ZERO;
      endcase
    end
  end

  // Accumulator: cleared on entry to INTEG, adds each registered beat sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (integ_entry_s) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (beat_valid_s) begin
      acc_r <= acc_r + {{(ACC_W-BEAT_SUM_W){beat_sum_s[BEAT_SUM_W-1]}}, beat_sum_s};
    end else begin
      acc_r <= acc_r;
    end
  end

  // Registered stream outputs and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tdata_r   <= {ACC_W{1'b0}};
      tvalid_r  <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
      tready_r  <= 1'b0;
    end else begin
      tready_r  <= 1'b1;
      busy_r    <= (next_state_s != IDLE);
      overrun_r <= overrun_r | (trig && (state_r != IDLE));
      if (load_result_s) begin
        tdata_r  <= acc_r;
        tvalid_r <= 1'b1;
      end else if ((state_r == HOLD) && m_axis_tready) begin
        tvalid_r <= 1'b0;
      end else begin
        tvalid_r <= tvalid_r;
      end
    end
  end

  assign s_axis_tready = tready_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign busy          = busy_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_adc_pulse_integrator.sv
// Scoreboard bench: expected window sums are queued as beats are driven and
// compared when the integrator presents a result that is accepted.
module tb_adc_pulse_integrator;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trig = 1'b0;
  logic [7:0]   delay_beats = 8'd0;
  logic [7:0]   win_len = 8'd0;
  logic [127:0] s_axis_tdata = 128'd0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         busy;
  logic         overrun;

  int     n_checks = 0;
  int     n_errors = 0;
  longint exp_q[$];

  adc_pulse_integrator dut (
    .clk           (clk),
    .rst           (rst),
    .trig          (trig),
    .delay_beats   (delay_beats),
    .win_len       (win_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint beat_sum(input logic [127:0] d);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'($signed(d[i*16 +: 16]));
    return s;
  endfunction

  function automatic logic [127:0] splat(input logic [15:0] v);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = v;
    return d;
  endfunction

  function automatic logic [127:0] rand_beat();
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'($urandom);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [127:0] d, input logic v);
    s_axis_tdata  = d;
    s_axis_tvalid = v;
    step();
  endtask

  task automatic start(input int dly, input int wl);
    delay_beats = 8'(dly);
    win_len     = 8'(wl);
    trig        = 1'b1;
    step();
    trig        = 1'b0;
  endtask

  task automatic wait_tvalid(input string tag);
    int n = 0;
    while (!m_axis_tvalid && n < 20) begin
      step();
      n++;
    end
    chk(tag, m_axis_tvalid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  // Scoreboard: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      if (exp_q.size() == 0) chk("spurious_result", m_axis_tvalid, 0);
      else chk("result", $signed(m_axis_tdata), exp_q.pop_front());
    end
  end

  initial begin
    longint       sum;
    longint       exp4;
    int           got;
    logic [127:0] d;

    rst = 1'b0;
    repeat (3) step();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    rst = 1'b1;
    step();
    chk("s_tready_on", s_axis_tready, 1);

    // All +1, delay 0, window 4: result 32, tvalid for one cycle 3 cycles after last beat.
    exp_q.push_back(64'sd32);
    start(0, 4);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) beat(splat(16'd1), 1'b1);
    chk("t1_tv_T1", m_axis_tvalid, 0);
    step();
    chk("t1_tv_T2", m_axis_tvalid, 0);
    step();
    chk("t1_tv_T3", m_axis_tvalid, 1);
    step();
    chk("t1_tv_T4", m_axis_tvalid, 0);
    chk("t1_busy_end", busy, 0);
    s_axis_tvalid = 1'b0;

    // Full-scale alternating beats, first two skipped.
    exp_q.push_back(-64'sd262152);
    start(2, 3);
    for (int i = 0; i < 5; i++) beat(splat((i % 2 == 0) ? 16'h8000 : 16'h7fff), 1'b1);
    s_axis_tvalid = 1'b0;
    wait_tvalid("t2_tvalid");
    step();
    wait_idle("t2_idle");

    // Valid toggling: only valid beats count, busy holds across the gaps.
    sum = 0;
    got = 0;
    start(0, 5);
    for (int k = 0; k < 20 && got < 5; k++) begin
      d = rand_beat();
      if (k % 2 == 1) begin
        sum += beat_sum(d);
        got++;
        if (got == 5) exp_q.push_back(sum);
      end
      beat(d, 1'(k % 2));
      chk("t3_busy", busy, 1);
    end
    s_axis_tvalid = 1'b0;
    wait_tvalid("t3_tvalid");
    step();
    wait_idle("t3_idle");
    chk("t3_overrun", overrun, 0);

    // Window length 0 behaves as 1.
    exp_q.push_back(64'sd56);
    start(0, 0);
    beat(splat(16'd7), 1'b1);
    beat(splat(16'd7), 1'b1);
    s_axis_tvalid = 1'b0;
    wait_tvalid("t5_tvalid");
    step();
    wait_idle("t5_idle");

    // Backpressure: result stable while held, a trigger in HOLD is flagged.
    m_axis_tready = 1'b0;
    d = rand_beat();
    exp4 = beat_sum(d);
    s_axis_tdata = d;
    start(0, 2);
    beat(d, 1'b1);
    d = rand_beat();
    exp4 += beat_sum(d);
    exp_q.push_back(exp4);
    beat(d, 1'b1);
    s_axis_tvalid = 1'b0;
    wait_tvalid("t4_tvalid");
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_tvalid", m_axis_tvalid, 1);
      chk("t4_hold_tdata", $signed(m_axis_tdata), exp4);
      trig = (i == 3);
      step();
      trig = 1'b0;
    end
    chk("t4_overrun", overrun, 1);
    chk("t4_busy_hold", busy, 1);
    m_axis_tready = 1'b1;
    step();
    chk("t4_tvalid_drop", m_axis_tvalid, 0);
    chk("t4_idle", busy, 0);

    // Reset mid-integration discards the partial window and clears the flags.
    start(0, 10);
    for (int i = 0; i < 4; i++) beat(rand_beat(), 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_tdata", m_axis_tdata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_s_tready", s_axis_tready, 0);
    s_axis_tvalid = 1'b0;
    repeat (6) step();
    chk("t6_still_idle", busy, 0);
    exp_q.push_back(64'sd48);
    start(0, 2);
    beat(splat(16'd3), 1'b1);
    beat(splat(16'd3), 1'b1);
    s_axis_tvalid = 1'b0;
    wait_tvalid("t6_tvalid_after");
    step();
    wait_idle("t6_idle_after");

    // Trigger on the cycle HOLD completes is ignored and flagged.
    exp_q.push_back(64'sd24);
    start(0, 1);
    beat(splat(16'd3), 1'b1);
    s_axis_tvalid = 1'b0;
    wait_tvalid("t7_tvalid");
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("t7_tvalid_drop", m_axis_tvalid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_overrun", overrun, 1);
    step();
    chk("t7_stays_idle", busy, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
